// File: rtl/mano_seq_ctrl.sv
// Mano basic computer timing sequencer: SC, RUN, one-hot T and fetch/decode/indirect strobes.
// Define MANO_INT_CYCLE_EN to add the interrupt (R) cycle with IEN/FGI/FGO inputs and R_CYC output.
module mano_seq_ctrl #(
  parameter int NUM_T      = 6,
  parameter bit AUTO_START = 1'b0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [15:0]      IR,
  input  logic             SC_CLR,
`ifdef MANO_INT_CYCLE_EN
  input  logic             IEN,
  input  logic             FGI,
  input  logic             FGO,
  output logic             R_CYC,
`endif
  output logic [NUM_T-1:0] T,
  output logic [7:0]       D,
  output logic             I,
  output logic             RUN,
  output logic             FETCH_AR,
  output logic             IR_LD,
  output logic             PC_INC,
  output logic             MEM_RD,
  output logic             ADDR_AR,
  output logic             INDIR_AR,
  output logic             SEQ_ERR
);
  // state  | meaning
  // S_HALT | RUN=0, SC held at 0, T all zero, waiting for START
  // S_RUN  | RUN=1, SC stepping through T0..T(NUM_T-1)
  typedef enum logic {S_HALT = 1'b0, S_RUN = 1'b1} state_t;

  localparam int             SCW     = $clog2(NUM_T);
  localparam logic [SCW-1:0] SC_LAST = SCW'(NUM_T - 1);
  localparam logic [SCW-1:0] SC_T2   = SCW'(2);
  localparam logic [SCW-1:0] SC_T3   = SCW'(3);

  state_t         state_q, state_d;
  logic [SCW-1:0] sc_q, sc_d;
  logic [7:0]     d_q, d_d;
  logic           i_q, i_d;
  logic           err_q, err_d;
  logic           r_q;
  logic           run;
  logic           hlt;
  logic           unused_ir_bits;

  assign unused_ir_bits = ^IR[11:1];
  assign run = (state_q == S_RUN);

  always_comb begin
    T = '0;
    for (int k = 0; k < NUM_T; k++)
      T[k] = run && (sc_q == SCW'(k));
  end

  assign hlt = T[3] & d_q[7] & ~i_q & IR[0];

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= AUTO_START ? S_RUN : S_HALT;
      sc_q    <= '0;
      d_q     <= '0;
      i_q     <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      d_q     <= d_d;
      i_q     <= i_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    d_d     = d_q;
    i_d     = i_q;
    err_d   = err_q;
    case (state_q)
      S_HALT: begin
        if (START) begin
          state_d = S_RUN;
          sc_d    = '0;
        end
      end
      S_RUN: begin
        if (hlt) begin
          state_d = S_HALT;
          sc_d    = '0;
        end else if (r_q && (sc_q == SC_T2)) begin
          sc_d = '0;
        end else if (SC_CLR && (sc_q >= SC_T3)) begin
          sc_d = '0;
        end else if (sc_q == SC_LAST) begin
          sc_d  = '0;
          err_d = 1'b1;
        end else begin
          sc_d = sc_q + 1'b1;
        end
        // Decode is skipped during RT2 so the interrupted instruction's D/I survive.
        if ((sc_q == SC_T2) && !r_q) begin
          d_d = 8'(1) << IR[14:12];
          i_d = IR[15];
        end
      end
      default: begin
        state_d = S_HALT;
        sc_d    = '0;
      end
    endcase
  end

`ifdef MANO_INT_CYCLE_EN
  logic r_d;

  always_comb begin
    r_d = r_q;
    if (r_q && T[2])
      r_d = 1'b0;
    else if (run && (sc_q >= SC_T3) && IEN && (FGI | FGO))
      r_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST)
      r_q <= 1'b0;
    else
      r_q <= r_d;
  end

  assign R_CYC = r_q;
`else
  assign r_q = 1'b0;
`endif

  assign D        = d_q;
  assign I        = i_q;
  assign RUN      = run;
  assign SEQ_ERR  = err_q;
  assign INDIR_AR = T[3] & ~d_q[7] & i_q;
  assign FETCH_AR = T[0] & ~r_q;
  assign IR_LD    = T[1] & ~r_q;
  assign PC_INC   = T[1] & ~r_q;
  assign ADDR_AR  = T[2] & ~r_q;
  assign MEM_RD   = T[1] | INDIR_AR;

endmodule

// File: tb/tb_mano_seq_ctrl.sv
// Self-checking bench for mano_seq_ctrl: behavioural model compared every cycle plus directed literal checks.
// Exercises the interrupt cycle only when MANO_INT_CYCLE_EN is defined.
module tb_mano_seq_ctrl;
  localparam int NUM_T = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             sc_clr = 1'b0;
  logic [15:0]      ir = 16'h0000;
  logic             ien = 1'b0, fgi = 1'b0, fgo = 1'b0;
  logic             r_cyc;
  logic [NUM_T-1:0] t;
  logic [7:0]       d;
  logic             i_bit, run, fetch_ar, ir_ld, pc_inc, mem_rd, addr_ar, indir_ar, seq_err;

  int n_tests = 0;
  int n_fail  = 0;

  mano_seq_ctrl #(.NUM_T(NUM_T), .AUTO_START(1'b0)) dut (
    .CLK(clk), .RST(rst), .START(start), .IR(ir), .SC_CLR(sc_clr),
`ifdef MANO_INT_CYCLE_EN
    .IEN(ien), .FGI(fgi), .FGO(fgo), .R_CYC(r_cyc),
`endif
    .T(t), .D(d), .I(i_bit), .RUN(run), .FETCH_AR(fetch_ar), .IR_LD(ir_ld),
    .PC_INC(pc_inc), .MEM_RD(mem_rd), .ADDR_AR(addr_ar), .INDIR_AR(indir_ar),
    .SEQ_ERR(seq_err)
  );

`ifndef MANO_INT_CYCLE_EN
  assign r_cyc = 1'b0;
`endif

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: a running flag, an instruction step number, the latched opcode as a one-hot byte.
  bit       m_ok = 0;
  bit       m_run, m_ind, m_err, m_r;
  int       m_step;
  bit [7:0] m_dec;

  always @(posedge clk) begin
    bit halt_now, next_r;
    if (rst) begin
      m_ok = 1; m_run = 0; m_step = 0; m_dec = 0; m_ind = 0; m_err = 0; m_r = 0;
    end else if (!m_run) begin
      if (start) begin m_run = 1; m_step = 0; end
    end else begin
      halt_now = (m_step == 3) && m_dec[7] && !m_ind && ir[0];
      next_r = m_r;
      if (m_r && m_step == 2) next_r = 0;
      else if (m_step >= 3 && ien && (fgi || fgo)) next_r = 1;
      if (m_step == 2 && !m_r) begin
        m_dec = 8'd1 << ir[14:12];
        m_ind = ir[15];
      end
      if (halt_now) begin m_run = 0; m_step = 0; end
      else if (m_r && m_step == 2) m_step = 0;
      else if (sc_clr && m_step >= 3) m_step = 0;
      else if (m_step == NUM_T - 1) begin m_step = 0; m_err = 1; end
      else m_step = m_step + 1;
      m_r = next_r;
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      bit fetching;
      fetching = m_run && !m_r;
      chk("T", 32'(t), m_run ? (32'd1 << m_step) : 32'd0);
      chk("RUN", 32'(run), 32'(m_run));
      chk("D", 32'(d), 32'(m_dec));
      chk("I", 32'(i_bit), 32'(m_ind));
      chk("SEQ_ERR", 32'(seq_err), 32'(m_err));
      chk("FETCH_AR", 32'(fetch_ar), 32'(fetching && m_step == 0));
      chk("IR_LD", 32'(ir_ld), 32'(fetching && m_step == 1));
      chk("PC_INC", 32'(pc_inc), 32'(fetching && m_step == 1));
      chk("ADDR_AR", 32'(addr_ar), 32'(fetching && m_step == 2));
      chk("INDIR_AR", 32'(indir_ar), 32'(m_run && m_step == 3 && !m_dec[7] && m_ind));
      chk("MEM_RD", 32'(mem_rd),
          32'(m_run && (m_step == 1 || (m_step == 3 && !m_dec[7] && m_ind))));
      chk("R_CYC", 32'(r_cyc), 32'(m_r));
    end
  end

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    step(2);
    rst = 1'b0;
    chk("rst_T", 32'(t), 32'h0);
    chk("rst_RUN", 32'(run), 32'h0);
    chk("rst_D", 32'(d), 32'h0);
    chk("rst_ERR", 32'(seq_err), 32'h0);
    step(3);
    chk("idle_T", 32'(t), 32'h0);

    // fetch of STA (0x3123)
    start = 1'b1; ir = 16'h3123;
    step(); start = 1'b0;
    chk("start_T0", 32'(t), 32'h01);
    chk("t0_FETCH_AR", 32'(fetch_ar), 32'h1);
    step();
    chk("t1_IR_LD", 32'(ir_ld), 32'h1);
    chk("t1_MEM_RD", 32'(mem_rd), 32'h1);
    step();
    chk("t2_ADDR_AR", 32'(addr_ar), 32'h1);
    step();
    chk("sta_D", 32'(d), 32'h08);
    chk("sta_I", 32'(i_bit), 32'h0);
    sc_clr = 1'b1;
    step(); sc_clr = 1'b0;
    chk("sta_end_T0", 32'(t), 32'h01);

    // indirect memory reference, ends at T5
    ir = 16'h8005;
    step(3);
    chk("ind_D", 32'(d), 32'h01);
    chk("ind_I", 32'(i_bit), 32'h1);
    chk("ind_INDIR_AR", 32'(indir_ar), 32'h1);
    chk("ind_MEM_RD", 32'(mem_rd), 32'h1);
    step(2);
    chk("ind_T5", 32'(t), 32'h20);
    sc_clr = 1'b1;
    step(); sc_clr = 1'b0;
    chk("ind_end_T0", 32'(t), 32'h01);
    chk("ind_ERR", 32'(seq_err), 32'h0);

    // register reference, 4 cycles
    ir = 16'h7800;
    step(3);
    chk("rr_D", 32'(d), 32'h80);
    chk("rr_INDIR_AR", 32'(indir_ar), 32'h0);
    sc_clr = 1'b1;
    step(); sc_clr = 1'b0;
    chk("rr_end_T0", 32'(t), 32'h01);

    // HLT
    ir = 16'h7001;
    step(3);
    chk("hlt_T3", 32'(t), 32'h08);
    step();
    chk("hlt_RUN", 32'(run), 32'h0);
    chk("hlt_T", 32'(t), 32'h0);
    step(10);
    chk("hlt_FETCH_AR", 32'(fetch_ar), 32'h0);
    chk("hlt_D_hold", 32'(d), 32'h80);
    ir = 16'h3123; start = 1'b1;
    step(); start = 1'b0;
    chk("resume_T0", 32'(t), 32'h01);

    // SC_CLR held through T0..T2 is ignored, honoured at T3
    sc_clr = 1'b1;
    step();
    chk("clr_ign_T1", 32'(t), 32'h02);
    step();
    chk("clr_ign_T2", 32'(t), 32'h04);
    step();
    chk("clr_T3", 32'(t), 32'h08);
    step(); sc_clr = 1'b0;
    chk("clr_end_T0", 32'(t), 32'h01);

    // overrun
    step(5);
    chk("ovr_T5", 32'(t), 32'h20);
    chk("ovr_ERR_before", 32'(seq_err), 32'h0);
    step();
    chk("ovr_T0", 32'(t), 32'h01);
    chk("ovr_ERR", 32'(seq_err), 32'h1);
    step(3); sc_clr = 1'b1;
    step(); sc_clr = 1'b0;
    chk("ovr_ERR_sticky", 32'(seq_err), 32'h1);

    // RST at T4
    step(4);
    chk("pre_rst_T4", 32'(t), 32'h10);
    rst = 1'b1;
    step(); rst = 1'b0;
    chk("midrst_T", 32'(t), 32'h0);
    chk("midrst_RUN", 32'(run), 32'h0);
    chk("midrst_D", 32'(d), 32'h0);
    chk("midrst_ERR", 32'(seq_err), 32'h0);

    // START while running is ignored
    start = 1'b1;
    step();
    chk("st_T0", 32'(t), 32'h01);
    step();
    chk("st_ign_T1", 32'(t), 32'h02);
    step(); start = 1'b0;
    chk("st_ign_T2", 32'(t), 32'h04);
    step(); sc_clr = 1'b1;
    step(); sc_clr = 1'b0;
    chk("st_end_T0", 32'(t), 32'h01);

`ifdef MANO_INT_CYCLE_EN
    // interrupt request during T4 of an instruction
    step(4);
    ien = 1'b1; fgi = 1'b1;
    step(); ien = 1'b0; fgi = 1'b0;
    chk("int_R_CYC_set", 32'(r_cyc), 32'h1);
    sc_clr = 1'b1;
    step(); sc_clr = 1'b0;
    chk("rt0_R_CYC", 32'(r_cyc), 32'h1);
    chk("rt0_FETCH_AR", 32'(fetch_ar), 32'h0);
    step();
    chk("rt1_IR_LD", 32'(ir_ld), 32'h0);
    step();
    chk("rt2_ADDR_AR", 32'(addr_ar), 32'h0);
    chk("rt2_D_hold", 32'(d), 32'h08);
    step();
    chk("post_int_T0", 32'(t), 32'h01);
    chk("post_int_R_CYC", 32'(r_cyc), 32'h0);
    chk("post_int_FETCH_AR", 32'(fetch_ar), 32'h1);
`endif

    step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mano_seq_ctrl.md
Name: mano_seq_ctrl

Overview:
- Timing/control sequencer for the Mano basic computer.
- Owns the sequence counter (SC) and the RUN flip-flop, and produces the one-hot timing vector T[5:0].
- Latches the decoded opcode D[7:0] and the indirect bit I from IR, and drives the fetch/decode/indirect strobes for AR, PC, IR and memory.
- Execute-phase units (IR_ARCH, AR/PC/AC control) consume T and D from this block and return SC_CLR at the end of each instruction.

Parameters:
- NUM_T, 6, number of timing states and width of T; legal range 4..16.
- AUTO_START, 0, reset value of RUN (1 = start fetching immediately after reset).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST  input  1  synchronous, active-high reset.
- START  input  1  sets RUN when halted.
- IR  input  16  instruction register contents.
- SC_CLR  input  1  end-of-instruction from execute logic.
- T  output  NUM_T  one-hot timing; all-zero when halted.
- D  output  8  registered one-hot decode of IR[14:12].
- I  output  1  registered IR[15].
- RUN  output  1  S flip-flop.
- FETCH_AR  output  1  AR <- PC.
- IR_LD  output  1  IR <- M[AR].
- PC_INC  output  1  PC <- PC+1.
- MEM_RD  output  1  memory read strobe.
- ADDR_AR  output  1  AR <- IR[11:0].
- INDIR_AR  output  1  AR <- M[AR].
- SEQ_ERR  output  1  sticky: SC overran without SC_CLR.

Behaviour:
- Reset: SC=0, RUN=AUTO_START, D=0, I=0, SEQ_ERR=0. T=0 if RUN=0, else T=1 (T0).
- T: T[k] = RUN & (SC==k). All strobes are combinational from the registered SC, RUN, D and I; there is no combinational path from inputs to T.
- START: if RUN=0 then RUN<=1 and SC<=0, so T0 is asserted the cycle after START. START while RUN=1 is ignored.
- Fetch and decode strobes:
  - T0: FETCH_AR.
  - T1: IR_LD, PC_INC, MEM_RD.
  - T2: ADDR_AR. On the same edge D <= onehot(IR[14:12]) and I <= IR[15]. D and I are therefore valid from T3 and hold until the next T2.
  - T3 with D[7]=0 and I=1: INDIR_AR and MEM_RD.
- SC advance: SC increments each cycle while RUN=1, except as below.
- SC_CLR (priority below RST and HLT):
  - Honoured only when SC>=3: SC<=0 on the next edge.
  - Ignored during T0..T2; SC keeps advancing.
- Overrun: at SC==NUM_T-1 without SC_CLR, SC wraps to 0 and SEQ_ERR<=1. SEQ_ERR clears only on RST.
- HLT: when T[3] & D[7] & ~I & IR[0], then RUN<=0 and SC<=0 on that edge, so T=0 next cycle. SC_CLR in the same cycle is redundant.
- Halted: SC holds 0, D and I hold their values, all strobes are 0.
- RST mid-instruction: everything returns to reset values immediately on that edge, and any pending START is lost.

Optional Feature:
- Macro: MANO_INT_CYCLE_EN.
- With the macro defined:
  - Adds inputs IEN, FGI, FGO (1 bit each) and output R_CYC (1 bit).
  - R flip-flop, reset 0. R<=1 on an edge where RUN & ~T[0] & ~T[1] & ~T[2] & IEN & (FGI|FGO).
  - While R=1: R_CYC=1, and FETCH_AR, IR_LD, PC_INC and ADDR_AR are forced to 0. The controller steps RT0..RT2 using SC 0..2.
  - At RT2: R<=0 and SC<=0.
  - D and I are not updated during RT2.
- Without the macro: no extra ports, R is constantly 0, and the behaviour is exactly as above.

Test Plan:
- RST=1 for 2 cycles with AUTO_START=0, then START pulse -> T=000000 until START; next cycle T=000001; T0..T2 strobes as specified; D=0x08 after IR=0x3123 at T2.
- Memory-reference indirect: IR=0x8005 -> D=0x01, I=1; T3 gives INDIR_AR=1, MEM_RD=1; SC_CLR at T5 -> T0 next cycle; SEQ_ERR=0.
- Register-reference: IR=0x7800 with SC_CLR at T3 -> one 4-cycle instruction; INDIR_AR never asserted.
- HLT: IR=0x7001 -> RUN=0 and T=0 the cycle after T3; strobes 0 for 10 cycles; START -> T0 resumes.
- Overrun and protocol checks: no SC_CLR -> after T5, SC wraps to T0 and SEQ_ERR=1 and stays 1. SC_CLR held during T0..T2 -> ignored. RST at T4 -> SC=0, D=0, RUN=0.
- MANO_INT_CYCLE_EN: IEN=1, FGI=1 asserted at T4 -> R_CYC=1 after the instruction's SC_CLR; 3 cycles with FETCH_AR=0; then normal T0 with R_CYC=0.
